// File: rtl/cfg_rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cfg_rf_pkg
// Description : Shared types, default reset vector and even-parity helper
//               for the configuration/status register file.
// Revision    : 1.0 - initial release
// ============================================================================
package cfg_rf_pkg;

  // Widest register the parity helper accepts; narrower words are zero-extended.
  localparam int CFG_RF_PAR_W = 64;

  // Default 16 x 8-bit reset image: reg2 = 0x81, reg3 = 0x20, all others 0.
  localparam logic [16*8-1:0] CFG_RF_RST_DEFAULT =
    128'h0000_0000_0000_0000_0000_0000_2081_0000;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_BOTH = 2'b11
  } cfg_rf_op_e;

  function automatic logic cfg_rf_parity_f(input logic [CFG_RF_PAR_W-1:0] d);
    return ^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_rf_parity.sv
`default_nettype none
// ============================================================================
// Module      : cfg_rf_parity
// Description : Per-entry even-parity storage and read-side check; only
//               instantiated when CFG_RF_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_rf_parity
  import cfg_rf_pkg::*;
#(
  parameter int                      DATA_W   = 8,
  parameter int                      DEPTH    = 16,
  parameter int                      ADDR_W   = $clog2(DEPTH),
  parameter logic [DEPTH*DATA_W-1:0] RST_VALS = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DEPTH-1:0]                we,
  input  logic [DEPTH-1:0][DATA_W-1:0]    wdata,
  input  logic [ADDR_W-1:0]               rd_addr,
  input  logic [DATA_W-1:0]               rd_word,
  output logic                            mismatch
);

  logic [DEPTH-1:0] r_par;
  logic             w_par_sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        r_par[i] <= cfg_rf_parity_f(CFG_RF_PAR_W'(RST_VALS[i*DATA_W +: DATA_W]));
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (we[i]) r_par[i] <= cfg_rf_parity_f(CFG_RF_PAR_W'(wdata[i]));
    end
  end

  always_comb begin
    w_par_sel = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (rd_addr == ADDR_W'(i)) w_par_sel = r_par[i];
  end

  assign mismatch = w_par_sel ^ cfg_rf_parity_f(CFG_RF_PAR_W'(rd_word));

endmodule
`default_nettype wire

// File: rtl/cfg_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : cfg_reg_file
// Description : Configuration/status register file with bus read/write,
//               hardware status-update port and parallel cfg outputs.
//               Optional stored parity: define CFG_RF_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_reg_file
  import cfg_rf_pkg::*;
#(
  parameter int                      DATA_W   = 8,
  parameter int                      DEPTH    = 16,
  parameter int                      ADDR_W   = $clog2(DEPTH),
  parameter int                      NUM_CFG  = 4,
  parameter logic [DEPTH-1:0]        RO_MASK  = '0,
  parameter logic [DEPTH*DATA_W-1:0] RST_VALS = CFG_RF_RST_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic                      rd_en,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      hw_we,
  input  logic [ADDR_W-1:0]         hw_addr,
  input  logic [DATA_W-1:0]         hw_data,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_valid,
  output logic                      bus_err,
  output logic                      par_err,
  output logic [NUM_CFG*DATA_W-1:0] cfg_out
);

  localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

  logic [DEPTH-1:0][DATA_W-1:0] r_regs;
  logic [DEPTH-1:0]             w_we;
  logic [DEPTH-1:0][DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0]            w_rd_word;
  logic                         w_ro_hit;
  logic                         w_addr_ok;
  logic                         w_bus_wr_ok;
  logic                         w_do_rd;
  logic                         w_err;
  cfg_rf_op_e                   w_op;

  assign w_op      = cfg_rf_op_e'({wr_en, rd_en});
  assign w_addr_ok = {1'b0, addr} < c_depth;

  // Explicit compare mux keeps out-of-range addresses (non-power-of-two DEPTH) well defined.
  always_comb begin
    w_rd_word = '0;
    w_ro_hit  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_W'(i)) begin
        w_rd_word = r_regs[i];
        w_ro_hit  = RO_MASK[i];
      end
    end
  end

  always_comb begin
    w_bus_wr_ok = 1'b0;
    w_do_rd     = 1'b0;
    w_err       = 1'b0;
    case (w_op)
      OP_WR: begin
        w_bus_wr_ok = w_addr_ok & ~w_ro_hit;
        w_err       = ~(w_addr_ok & ~w_ro_hit);
      end
      OP_RD: begin
        w_do_rd = 1'b1;
        w_err   = ~w_addr_ok;
      end
      OP_BOTH: w_err = 1'b1;
      default: ;
    endcase
  end

  // An accepted bus write takes priority over a hardware update to the same entry.
  always_comb begin
    w_we    = '0;
    w_wdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_we[i]    = (w_bus_wr_ok && addr == ADDR_W'(i)) || (hw_we && hw_addr == ADDR_W'(i));
      w_wdata[i] = (w_bus_wr_ok && addr == ADDR_W'(i)) ? wr_data : hw_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_regs <= RST_VALS;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (w_we[i]) r_regs[i] <= w_wdata[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      rd_valid <= w_do_rd;
      bus_err  <= w_err;
      if (w_do_rd) rd_data <= w_addr_ok ? w_rd_word : '0;
    end
  end

`ifdef CFG_RF_PARITY_EN
  logic w_par_mismatch;

  cfg_rf_parity #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .RST_VALS (RST_VALS)
  ) u_parity (
    .clk      (clk),
    .rst      (rst),
    .we       (w_we),
    .wdata    (w_wdata),
    .rd_addr  (addr),
    .rd_word  (w_rd_word),
    .mismatch (w_par_mismatch)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) par_err <= 1'b0;
    else      par_err <= w_do_rd & w_addr_ok & w_par_mismatch;
  end
`else
  assign par_err = 1'b0;
`endif

  assign cfg_out = r_regs[NUM_CFG-1:0];

endmodule
`default_nettype wire

// File: tb/tb_cfg_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_cfg_reg_file
// Description : Scoreboard bench for cfg_reg_file (DEPTH=12, reg1 read-only).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cfg_reg_file;
  import cfg_rf_pkg::*;

  localparam int          DEPTH = 12;
  localparam logic [11:0] RO    = 12'h002;
`ifdef CFG_RF_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  typedef struct {
    logic       w;
    logic       r;
    logic [3:0] a;
    logic [7:0] d;
    logic       hwe;
    logic [3:0] ha;
    logic [7:0] hd;
  } op_t;

  typedef struct {
    logic [7:0]  data;
    logic        valid;
    logic        err;
    logic        par;
    logic [31:0] cfg;
  } exp_t;

  logic        clk, rst, wr_en, rd_en, hw_we;
  logic [3:0]  addr, hw_addr;
  logic [7:0]  wr_data, hw_data, rd_data;
  logic        rd_valid, bus_err, par_err;
  logic [31:0] cfg_out;

  logic [7:0]  model [16];
  logic        model_par [16];
  logic [7:0]  last_data;
  exp_t        exp_q [$];
  int          checks, errors;

  cfg_reg_file #(
    .DATA_W   (8),
    .DEPTH    (DEPTH),
    .ADDR_W   (4),
    .NUM_CFG  (4),
    .RO_MASK  (RO),
    .RST_VALS (96'h0000_0000_0000_0000_2081_0000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr     (addr),
    .wr_data  (wr_data),
    .hw_we    (hw_we),
    .hw_addr  (hw_addr),
    .hw_data  (hw_data),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .bus_err  (bus_err),
    .par_err  (par_err),
    .cfg_out  (cfg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    model[2] = 8'h81;
    model[3] = 8'h20;
    for (int i = 0; i < 16; i++) model_par[i] = cfg_rf_parity_f(CFG_RF_PAR_W'(model[i]));
    last_data = 8'h00;
    exp_q.delete();
  endtask

  // Drives one bus/hw cycle, predicts its outcome, and returns just after the edge.
  task automatic drive(input op_t o);
    exp_t e;
    logic bus_ok;
    wr_en = o.w; rd_en = o.r; addr = o.a; wr_data = o.d;
    hw_we = o.hwe; hw_addr = o.ha; hw_data = o.hd;
    e.valid = 1'b0; e.err = 1'b0; e.par = 1'b0; e.data = last_data;
    bus_ok = 1'b0;
    if (o.w && o.r) begin
      e.err = 1'b1;
    end else if (o.r) begin
      e.valid = 1'b1;
      if (o.a < DEPTH) begin
        e.data = model[o.a];
        e.par  = PAR_ON && (model_par[o.a] != cfg_rf_parity_f(CFG_RF_PAR_W'(model[o.a])));
      end else begin
        e.data = 8'h00;
        e.err  = 1'b1;
      end
    end else if (o.w) begin
      if (o.a < DEPTH && !RO[o.a]) bus_ok = 1'b1;
      else e.err = 1'b1;
    end
    if (o.hwe && o.ha < DEPTH && !(bus_ok && o.ha == o.a)) begin
      model[o.ha]     = o.hd;
      model_par[o.ha] = cfg_rf_parity_f(CFG_RF_PAR_W'(o.hd));
    end
    if (bus_ok) begin
      model[o.a]     = o.d;
      model_par[o.a] = cfg_rf_parity_f(CFG_RF_PAR_W'(o.d));
    end
    last_data = e.data;
    e.cfg = {model[3], model[2], model[1], model[0]};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    op_t  o;
    exp_t e;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wr_data = '0;
    hw_we = 1'b0; hw_addr = '0; hw_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rd_data !== 8'h00 || rd_valid !== 1'b0 || bus_err !== 1'b0 || par_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got d=%h v=%b be=%b pe=%b, want 00 0 0 0", rd_data, rd_valid, bus_err, par_err);
    end
    checks++;
    if (cfg_out !== 32'h2081_0000) begin
      errors++;
      $display("FAIL reset_cfg: got %h, want 20810000", cfg_out);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      o = '{1'b0, 1'b1, 4'(i), 8'h00, 1'b0, 4'd0, 8'h00};
      drive(o);
      e = exp_q.pop_front();
      checks++;
      if (rd_data !== e.data || rd_valid !== e.valid || bus_err !== e.err || par_err !== e.par || cfg_out !== e.cfg) begin
        errors++;
        $display("FAIL reset_read[%0d]: got d=%h v=%b be=%b pe=%b cfg=%h, want d=%h v=%b be=%b pe=%b cfg=%h",
                 i, rd_data, rd_valid, bus_err, par_err, cfg_out, e.data, e.valid, e.err, e.par, e.cfg);
      end
    end
  endtask

  task automatic test_write_read;
    op_t  ops [8];
    exp_t e;
    ops = '{'{1'b1, 1'b0, 4'd3,  8'h5A, 1'b0, 4'd0, 8'h00},
            '{1'b0, 1'b1, 4'd3,  8'h00, 1'b0, 4'd0, 8'h00},
            '{1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 4'd0, 8'h00},
            '{1'b1, 1'b0, 4'd0,  8'hA5, 1'b0, 4'd0, 8'h00},
            '{1'b1, 1'b0, 4'd11, 8'hC3, 1'b0, 4'd0, 8'h00},
            '{1'b0, 1'b1, 4'd0,  8'h00, 1'b0, 4'd0, 8'h00},
            '{1'b0, 1'b1, 4'd11, 8'h00, 1'b0, 4'd0, 8'h00},
            '{1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 4'd0, 8'h00}};
    for (int i = 0; i < $size(ops); i++) begin
      drive(ops[i]);
      e = exp_q.pop_front();
      checks++;
      if (rd_data !== e.data || rd_valid !== e.valid || bus_err !== e.err || par_err !== e.par || cfg_out !== e.cfg) begin
        errors++;
        $display("FAIL write_read[%0d]: got d=%h v=%b be=%b pe=%b cfg=%h, want d=%h v=%b be=%b pe=%b cfg=%h",
                 i, rd_data, rd_valid, bus_err, par_err, cfg_out, e.data, e.valid, e.err, e.par, e.cfg);
      end
    end
  endtask

  task automatic test_rejected;
    op_t  ops [6];
    exp_t e;
    ops = '{'{1'b1, 1'b0, 4'd1,  8'hFF, 1'b0, 4'd0, 8'h00},
            '{1'b0, 1'b1, 4'd1,  8'h00, 1'b0, 4'd0, 8'h00},
            '{1'b1, 1'b0, 4'd13, 8'hAA, 1'b0, 4'd0, 8'h00},
            '{1'b0, 1'b1, 4'd13, 8'h00, 1'b0, 4'd0, 8'h00},
            '{1'b0, 1'b1, 4'd15, 8'h00, 1'b0, 4'd0, 8'h00},
            '{1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 4'd0, 8'h00}};
    for (int i = 0; i < $size(ops); i++) begin
      drive(ops[i]);
      e = exp_q.pop_front();
      checks++;
      if (rd_data !== e.data || rd_valid !== e.valid || bus_err !== e.err || par_err !== e.par || cfg_out !== e.cfg) begin
        errors++;
        $display("FAIL rejected[%0d]: got d=%h v=%b be=%b pe=%b cfg=%h, want d=%h v=%b be=%b pe=%b cfg=%h",
                 i, rd_data, rd_valid, bus_err, par_err, cfg_out, e.data, e.valid, e.err, e.par, e.cfg);
      end
    end
  endtask

  task automatic test_collision;
    op_t  ops [11];
    exp_t e;
    ops = '{'{1'b1, 1'b0, 4'd5, 8'h11, 1'b1, 4'd5,  8'h22},
            '{1'b0, 1'b1, 4'd5, 8'h00, 1'b0, 4'd0,  8'h00},
            '{1'b1, 1'b1, 4'd4, 8'hEE, 1'b0, 4'd0,  8'h00},
            '{1'b0, 1'b1, 4'd4, 8'h00, 1'b0, 4'd0,  8'h00},
            '{1'b1, 1'b0, 4'd8, 8'h44, 1'b1, 4'd7,  8'h33},
            '{1'b0, 1'b1, 4'd7, 8'h00, 1'b0, 4'd0,  8'h00},
            '{1'b0, 1'b1, 4'd8, 8'h00, 1'b0, 4'd0,  8'h00},
            '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd1,  8'h99},
            '{1'b0, 1'b1, 4'd1, 8'h00, 1'b0, 4'd0,  8'h00},
            '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd14, 8'h55},
            '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd2,  8'h3E}};
    for (int i = 0; i < $size(ops); i++) begin
      drive(ops[i]);
      e = exp_q.pop_front();
      checks++;
      if (rd_data !== e.data || rd_valid !== e.valid || bus_err !== e.err || par_err !== e.par || cfg_out !== e.cfg) begin
        errors++;
        $display("FAIL collision[%0d]: got d=%h v=%b be=%b pe=%b cfg=%h, want d=%h v=%b be=%b pe=%b cfg=%h",
                 i, rd_data, rd_valid, bus_err, par_err, cfg_out, e.data, e.valid, e.err, e.par, e.cfg);
      end
    end
  endtask

  task automatic test_back_to_back;
    op_t  ops [8];
    exp_t e;
    ops = '{'{1'b0, 1'b1, 4'd6, 8'h00, 1'b1, 4'd6, 8'h77},
            '{1'b0, 1'b1, 4'd6, 8'h00, 1'b0, 4'd0, 8'h00},
            '{1'b0, 1'b1, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00},
            '{1'b0, 1'b1, 4'd3, 8'h00, 1'b0, 4'd0, 8'h00},
            '{1'b0, 1'b1, 4'd5, 8'h00, 1'b0, 4'd0, 8'h00},
            '{1'b0, 1'b1, 4'd5, 8'h00, 1'b1, 4'd5, 8'h6C},
            '{1'b0, 1'b1, 4'd5, 8'h00, 1'b0, 4'd0, 8'h00},
            '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00}};
    for (int i = 0; i < $size(ops); i++) begin
      drive(ops[i]);
      e = exp_q.pop_front();
      checks++;
      if (rd_data !== e.data || rd_valid !== e.valid || bus_err !== e.err || par_err !== e.par || cfg_out !== e.cfg) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got d=%h v=%b be=%b pe=%b cfg=%h, want d=%h v=%b be=%b pe=%b cfg=%h",
                 i, rd_data, rd_valid, bus_err, par_err, cfg_out, e.data, e.valid, e.err, e.par, e.cfg);
      end
    end
  endtask

  task automatic test_reset_abort;
    wr_en = 1'b0; rd_en = 1'b1; addr = 4'd2; hw_we = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h00 || bus_err !== 1'b0 || cfg_out !== 32'h2081_0000) begin
      errors++;
      $display("FAIL reset_abort: got v=%b d=%h be=%b cfg=%h, want v=0 d=00 be=0 cfg=20810000",
               rd_valid, rd_data, bus_err, cfg_out);
    end
    rd_en = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_parity;
    op_t  ops [5];
    exp_t e;
`ifdef CFG_RF_PARITY_EN
    logic pb;
`endif
    ops = '{'{1'b1, 1'b0, 4'd2, 8'h0F, 1'b0, 4'd0, 8'h00},
            '{1'b0, 1'b1, 4'd2, 8'h00, 1'b0, 4'd0, 8'h00},
            '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00},
            '{1'b1, 1'b0, 4'd2, 8'h3C, 1'b0, 4'd0, 8'h00},
            '{1'b0, 1'b1, 4'd2, 8'h00, 1'b0, 4'd0, 8'h00}};
    for (int i = 0; i < $size(ops); i++) begin
`ifdef CFG_RF_PARITY_EN
      if (i == 1) begin
        pb = dut.u_parity.r_par[2];
        force dut.u_parity.r_par[2] = ~pb;
        model_par[2] = ~model_par[2];
      end
      if (i == 3) release dut.u_parity.r_par[2];
`endif
      drive(ops[i]);
      e = exp_q.pop_front();
      checks++;
      if (rd_data !== e.data || rd_valid !== e.valid || bus_err !== e.err || par_err !== e.par || cfg_out !== e.cfg) begin
        errors++;
        $display("FAIL parity[%0d]: got d=%h v=%b be=%b pe=%b cfg=%h, want d=%h v=%b be=%b pe=%b cfg=%h",
                 i, rd_data, rd_valid, bus_err, par_err, cfg_out, e.data, e.valid, e.err, e.par, e.cfg);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_read();
    test_rejected();
    test_collision();
    test_back_to_back();
    test_reset_abort();
    test_parity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
